// File: rtl/iterative_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops plus a shift-add multiplier
// that retires one multiplier bit per cycle. Results are registered and held until the next done.
module iterative_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int unsigned  SW       = $clog2(WIDTH);
  localparam int unsigned  CW       = SW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_MUL  = 4'b0010,
    OP_AND  = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_OR   = 4'b0101,
    OP_NOR  = 4'b0110,
    OP_SLL  = 4'b1000,
    OP_SRL  = 4'b1001,
    OP_SRA  = 4'b1011,
    OP_ROL  = 4'b1100,
    OP_ROR  = 4'b1101,
    OP_SLT  = 4'b1110,
    OP_SLTU = 4'b1111
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] sum, diff, alu_res, mul_step;
  logic [SW-1:0]    shamt, shamt_n;
  logic             alu_ovf;

  // Single-cycle datapath, evaluated directly from the inputs on the start edge.
  always_comb begin
    sum     = operand_a + operand_b;
    diff    = operand_a - operand_b;
    shamt   = operand_b[SW-1:0];
    shamt_n = -shamt;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != operand_a[WIDTH-1]);
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_NOR:  alu_res = ~(operand_a | operand_b);
      OP_SLL:  alu_res = operand_a << shamt;
      OP_SRL:  alu_res = operand_a >> shamt;
      OP_SRA:  alu_res = $signed(operand_a) >>> shamt;
      // Complementary amount is 0 when shamt is 0, so both halves equal operand_a.
      OP_ROL:  alu_res = (operand_a << shamt) | (operand_a >> shamt_n);
      OP_ROR:  alu_res = (operand_a >> shamt) | (operand_a << shamt_n);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, operand_a < operand_b};
      default: alu_res = '0;
    endcase
  end

  assign mul_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (alu_op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            mcand_d  = operand_a;
            mplier_d = operand_b;
            acc_d    = '0;
          end else begin
            state_d  = S_DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            ovf_d    = alu_ovf;
          end
        end
      end
      S_MUL: begin
        acc_d    = mul_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        // Last iteration retires directly into the result so DONE follows WIDTH MUL cycles.
        if (cnt_q == CNT_LAST) begin
          state_d  = S_DONE;
          result_d = mul_step;
          zero_d   = (mul_step == '0);
          ovf_d    = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu: expectations are queued at start and
// matched against each done pulse, including the cycle it arrives in.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [31:0] result;
  logic        zero, overflow, busy, done;

  iterative_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .alu_op    (alu_op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic        z;
    logic        ov;
    int          cy;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic ov);
    logic [32:0] s;
    logic [63:0] w;
    logic [4:0]  sh;
    sh = b[4:0];
    r  = '0;
    ov = 1'b0;
    case (op)
      4'h0: begin s = {a[31], a} + {b[31], b}; r = s[31:0]; ov = s[32] ^ s[31]; end
      4'h1: begin s = {a[31], a} - {b[31], b}; r = s[31:0]; ov = s[32] ^ s[31]; end
      4'h2: begin w = {32'h0, a} * {32'h0, b}; r = w[31:0]; end
      4'h3: r = a & b;
      4'h4: r = a ^ b;
      4'h5: r = a | b;
      4'h6: r = ~(a | b);
      4'h8: r = a << sh;
      4'h9: r = a >> sh;
      4'hB: r = $signed(a) >>> sh;
      4'hC: begin w = {a, a} << sh; r = w[63:32]; end
      4'hD: begin w = {a, a} >> sh; r = w[31:0]; end
      4'hE: r = ($signed(a) < $signed(b)) ? 32'h1 : 32'h0;
      4'hF: r = (a < b) ? 32'h1 : 32'h0;
      default: r = '0;
    endcase
  endtask

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int lat);
    exp_t e;
    model(op, a, b, e.r, e.ov);
    e.z  = (e.r == 32'h0);
    e.cy = cyc + lat;
    sb.push_back(e);
  endtask

  // Issue one op from IDLE; bc returns how many cycles busy stayed high.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit poke, output int bc);
    int guard;
    guard = 0;
    while (busy && guard < 200) begin @(posedge clk); #1; guard++; end
    if (busy) chk("idle_timeout", 32'(busy), 32'h0);
    alu_op = op; operand_a = a; operand_b = b; start = 1'b1;
    push(op, a, b, (op == 4'h2) ? 33 : 1);
    @(posedge clk); #1;
    start = 1'b0;
    alu_op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
    bc = 0; guard = 0;
    while (busy && guard < 200) begin
      bc++;
      if (poke && bc == 5) begin alu_op = 4'h0; start = 1'b1; end
      if (poke && bc == 7) start = 1'b0;
      @(posedge clk); #1;
      guard++;
    end
    start = 1'b0;
    if (busy) chk("busy_timeout", 32'(busy), 32'h0);
  endtask

  logic [31:0] last_r = '0;
  logic        last_z = 1'b0, last_o = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_r = '0; last_z = 1'b0; last_o = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'h0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.r);
        chk("zero", 32'(zero), 32'(e.z));
        chk("overflow", 32'(overflow), 32'(e.ov));
        chk("done_cycle", 32'(cyc), 32'(e.cy));
      end
      last_r = result; last_z = zero; last_o = overflow;
    end else begin
      chk("hold_result", result, last_r);
      chk("hold_flags", {30'h0, zero, overflow}, {30'h0, last_z, last_o});
    end
  end

  logic [3:0] ops [16] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                          4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h2};

  initial begin
    int bc, t0, guard;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'h0, zero, overflow, busy}, 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(4'h0, 32'h7FFFFFFF, 32'h00000001, 0, bc);
    chk("busy_add", 32'(bc), 32'd1);
    do_op(4'h0, 32'hFFFFFFFF, 32'h00000001, 0, bc);
    do_op(4'h1, 32'd5, 32'd5, 0, bc);
    do_op(4'h1, 32'h80000000, 32'h00000001, 0, bc);
    do_op(4'hE, 32'hFFFFFFFF, 32'h00000001, 0, bc);
    do_op(4'hF, 32'hFFFFFFFF, 32'h00000001, 0, bc);
    do_op(4'h2, 32'h00010001, 32'h00010001, 1, bc);
    chk("busy_mul", 32'(bc), 32'd33);
    do_op(4'hB, 32'h80000000, 32'h00000004, 0, bc);
    do_op(4'hD, 32'h00000001, 32'h00000001, 0, bc);
    do_op(4'hC, 32'h80000000, 32'h00000000, 0, bc);
    do_op(4'h8, 32'h0000000F, 32'hFFFFFFE4, 0, bc);
    do_op(4'h9, 32'h80000000, 32'h0000001F, 0, bc);
    do_op(4'h9, 32'h80000000, 32'h00000000, 0, bc);
    do_op(4'h0, 32'h12345678, 32'h11111111, 0, bc);
    do_op(4'h7, 32'h5, 32'h6, 0, bc);
    do_op(4'h0, 32'h12345678, 32'h11111111, 0, bc);
    do_op(4'hA, 32'h5, 32'h6, 0, bc);
    do_op(4'h6, 32'h0F0F0000, 32'h00F0F0F0, 0, bc);
    do_op(4'h2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, bc);

    // Reset ten cycles into a multiply: no done, outputs cleared.
    guard = 0;
    while (busy && guard < 200) begin @(posedge clk); #1; guard++; end
    alu_op = 4'h2; operand_a = 32'h1234; operand_b = 32'h5678; start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t0 + 10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_result", result, 32'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_op(4'h0, 32'd2, 32'd3, 0, bc);

    // Continuous start: only operands present in IDLE cycles are taken.
    guard = 0;
    while (busy && guard < 200) begin @(posedge clk); #1; guard++; end
    for (int i = 0; i < 10; i++) begin
      alu_op = 4'h0; operand_a = $urandom; operand_b = $urandom; start = 1'b1;
      if (i % 2 == 0) push(4'h0, operand_a, operand_b, 1);
      @(posedge clk); #1;
    end
    start = 1'b0;

    for (int i = 0; i < 40; i++) begin
      do_op(ops[$urandom_range(0, (i % 8 == 7) ? 15 : 14)], $urandom, $urandom, 0, bc);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("drain", 32'(sb.size()), 32'h0);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
